mux_2to1_rr_arb: RTL
====================

// Module: mux_2to1_rr_arb
// PURPOSE
//   Merging counterpart of the 1-to-2 demux: arbitrates two valid/ready input
//   channels onto one registered output channel. When both inputs request,
//   the grant alternates (round-robin). Each output beat is tagged with its
//   source lane so a downstream 1-to-2 demux can route it back out.
//   One beat per cycle sustained, 1-cycle latency, full backpressure support.
// PARAMETERS
//   DATA_W  8  width of the data path, in bits
// PORTS
//   clk        in   1       single clock; all state updates on rising edge
//   rst        in   1       synchronous reset, active-high
//   in0_data   in   DATA_W  lane 0 payload
//   in0_valid  in   1       lane 0 has a beat
//   in0_ready  out  1       lane 0 beat accepted this cycle (valid&ready)
//   in1_data   in   DATA_W  lane 1 payload
//   in1_valid  in   1       lane 1 has a beat
//   in1_ready  out  1       lane 1 beat accepted this cycle
//   out_data   out  DATA_W  registered payload
//   out_sel    out  1       source lane of out_data (0 or 1)
//   out_valid  out  1       output register holds a beat
//   out_ready  in   1       downstream accepts out beat this cycle
// BEHAVIOUR
//   - Reset (rst=1 at clk edge):
//     - out_valid=0, out_data=0, out_sel=0, prio=0 (lane 0 favoured first).
//     - Any held beat is discarded. in0_ready/in1_ready are forced 0 while rst=1.
//   - Output register state machine (EMPTY / FULL, i.e. out_valid):
//     - load_en = ~out_valid | out_ready.
//     - EMPTY -> FULL: a grant occurs.
//     - FULL -> EMPTY: out_ready=1 and no grant.
//     - FULL -> FULL: either (a) stalled, out_ready=0; or (b) drained and
//       reloaded in the same cycle (back-to-back, no bubble).
//   - Grant (combinational; only when load_en=1):
//     - g0 = in0_valid & (~in1_valid | prio==0).
//     - g1 = in1_valid & (~in0_valid | prio==1).
//     - At most one of g0/g1 is 1. inK_ready = load_en & gK.
//     - inK_ready may depend on the other lane's valid. There is no
//       combinational path from out_ready to out_data.
//   - On grant to lane k:
//     - out_data <= ink_data; out_sel <= k; out_valid <= 1.
//     - prio <= ~k. prio changes only on a grant, so a lone requester never
//       moves priority away from the lane that is waiting.
//   - Stall (out_valid=1, out_ready=0):
//     - out_data and out_sel are held stable; in0_ready=in1_ready=0.
//   - Latency: an input beat accepted at edge N appears on out_* after edge N.
//     A beat is never lost or duplicated.
//   - Fairness: with both lanes continuously valid and out_ready=1, the grants
//     alternate 0,1,0,1... No lane waits more than one granted beat.
//   - Inputs are sampled only when the handshake completes; in_data need not
//     be stable otherwise.
// TESTING
//   1. Reset: rst=1 for 2 cycles with both valid=1 -> out_valid=0, out_data=0,
//      in*_ready=0. First grant after reset goes to lane 0.
//   2. Lone lane: in1_valid=1, data 0x11,0x22,0x33; in0_valid=0; out_ready=1
//      -> out_data 0x11,0x22,0x33 on consecutive cycles, out_sel=1, no bubbles.
//   3. Contention: both valid, in0=0xA0.., in1=0xB0.., out_ready=1 for 6 cycles
//      -> out_sel sequence 0,1,0,1,0,1; data 0xA0,0xB0,0xA1,0xB1,0xA2,0xB2.
//   4. Backpressure: hold out_ready=0 for 3 cycles while out_data=0x5A
//      -> out_data/out_sel unchanged, in*_ready=0. Release -> next beat the
//      following cycle with no loss.
//   5. Reset mid-operation: out_valid=1 (0x77 held, out_ready=0), assert rst
//      for 1 cycle -> out_valid=0 next edge, 0x77 never delivered, prio=0.
//   6. Scoreboard: random valids/out_ready for 2000 cycles -> per-lane output
//      order matches input order, each beat delivered exactly once.

Source files
------------

// File: rtl/mux_2to1_rr_arb_if.sv
// ----------------------------------------------------------------------------
// mux_2to1_rr_arb_if
//   Bundle of the three valid/ready channels around the 2-to-1 round-robin
//   merge: two input lanes and one tagged output channel.
//
//   Signals
//     in0_data/in0_valid/in0_ready   lane 0 channel (ready driven by arbiter)
//     in1_data/in1_valid/in1_ready   lane 1 channel (ready driven by arbiter)
//     out_data/out_sel/out_valid     registered merged beat and its source lane
//     out_ready                      downstream accepts the out beat
//
//   Modports
//     master  the environment: drives lane payloads/valids and out_ready
//     slave   the arbiter: drives lane readies and the output channel
// ----------------------------------------------------------------------------
interface mux_2to1_rr_arb_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] in0_data;
    logic              in0_valid;
    logic              in0_ready;

    logic [DATA_W-1:0] in1_data;
    logic              in1_valid;
    logic              in1_ready;

    logic [DATA_W-1:0] out_data;
    logic              out_sel;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output in0_data, in0_valid,
        input  in0_ready,
        output in1_data, in1_valid,
        input  in1_ready,
        input  out_data, out_sel, out_valid,
        output out_ready
    );

    modport slave (
        input  in0_data, in0_valid,
        output in0_ready,
        input  in1_data, in1_valid,
        output in1_ready,
        output out_data, out_sel, out_valid,
        input  out_ready
    );
endinterface

// File: rtl/mux_2to1_rr_arb.sv
// ----------------------------------------------------------------------------
// mux_2to1_rr_arb
//   Merges two valid/ready input lanes onto one registered output channel.
//   When both lanes request in the same cycle the grant alternates between
//   them; each output beat carries its source lane in out_sel so a downstream
//   1-to-2 demux can route it back. Sustains one beat per cycle with a single
//   cycle of latency and full backpressure.
//
//   Ports
//     clk   in   single clock, all state updates on the rising edge
//     rst   in   synchronous reset, active-high
//     bus   slave modport of mux_2to1_rr_arb_if (both input lanes and the
//           output channel)
// ----------------------------------------------------------------------------
module mux_2to1_rr_arb #(
    parameter int DATA_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    mux_2to1_rr_arb_if.slave        bus
);

    // Output register occupancy; FULL is exactly out_valid.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic              sel_q,   sel_d;
    // Lane favoured on the next contended cycle.
    logic              prio_q,  prio_d;

    logic              load_en;
    logic              g0;
    logic              g1;

    always_comb begin
        // NOTE: every signal written here is given its default first, so no
        // branch can leave one unassigned and infer a latch.
        state_d = state_q;
        data_d  = data_q;
        sel_d   = sel_q;
        prio_d  = prio_q;

        // The register can take a new beat when it is empty or its current
        // beat leaves this cycle; this allows drain and reload back-to-back.
        load_en = (state_q == EMPTY) | bus.out_ready;

        // A lone requester always wins; on contention prio picks the lane.
        g0 = load_en & bus.in0_valid & (~bus.in1_valid | ~prio_q);
        g1 = load_en & bus.in1_valid & (~bus.in0_valid |  prio_q);

        if (g0) begin
            state_d = FULL;
            data_d  = bus.in0_data;
            sel_d   = 1'b0;
            prio_d  = 1'b1;
        end else if (g1) begin
            state_d = FULL;
            data_d  = bus.in1_data;
            sel_d   = 1'b1;
            prio_d  = 1'b0;
        end else if (bus.out_ready) begin
            // Nothing granted: the held beat (if any) drains.
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q <= EMPTY;
            data_q  <= '0;
            sel_q   <= 1'b0;
            prio_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            prio_q  <= prio_d;
        end
    end

    // Readies are gated by rst so nothing is accepted during a reset cycle.
    assign bus.in0_ready = g0 & ~rst;
    assign bus.in1_ready = g1 & ~rst;

    // Output comes straight from flops: no combinational out_ready->out_data path.
    assign bus.out_data  = data_q;
    assign bus.out_sel   = sel_q;
    assign bus.out_valid = (state_q == FULL);

endmodule
